// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data memory.
// Valid/ready on both channels; one transaction in flight at a time.
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid,
    output req_addr,
    output req_wdata,
    output req_we,
    output req_size,
    output req_unsigned,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_wdata,
    input  req_we,
    input  req_size,
    input  req_unsigned,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory with fixed wait states, little-endian
// sub-word stores and sign/zero-extending loads.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 131072,
  parameter int WAIT_STATES = 2
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  fire;
  logic                  bad;
  logic [2:0]            nbytes;
  logic [32:0]           end_addr;

  logic [AW-1:0]         a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_we;
  logic [1:0]            a_size;
  logic                  a_uns;
  logic                  commit;

  logic [7:0]            mem [MEM_BYTES];
  logic [AW-1:0]         i0, i1, i2, i3;
  logic [7:0]            b0, b1, b2, b3;
  logic [DATA_WIDTH-1:0] ld;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign fire = bus.req_valid && bus.req_ready;

  // Size decode and rejection check on the live request.
  always_comb begin
    nbytes = 3'd0;
    unique case (1'b1)
      bus.req_size == 2'b00: nbytes = 3'd1;
      bus.req_size == 2'b01: nbytes = 3'd2;
      bus.req_size == 2'b10: nbytes = 3'd4;
      default:               nbytes = 3'd0;
    endcase
    end_addr = {1'b0, bus.req_addr} + 33'(nbytes);
    bad = (nbytes == 3'd0)
       || (bus.req_size == 2'b01 && bus.req_addr[0])
       || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
       || (end_addr > 33'(MEM_BYTES));
  end

  // Zero wait states access straight from the bus; otherwise from the capture.
  always_comb begin
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_we    = we_q;
    a_size  = size_q;
    a_uns   = uns_q;
    if (state_q == IDLE) begin
      a_addr  = bus.req_addr[AW-1:0];
      a_wdata = bus.req_wdata;
      a_we    = bus.req_we;
      a_size  = bus.req_size;
      a_uns   = bus.req_unsigned;
    end
  end

  assign commit = rst && (
    (state_q == IDLE && fire && !bad && WAIT_STATES == 0) ||
    (state_q == WAIT && cnt_q == 4'd1));

  // Aligned accesses never carry, so OR-ing the lane gives addr+k.
  assign i0 = a_addr;
  assign i1 = a_addr | AW'(1);
  assign i2 = a_addr | AW'(2);
  assign i3 = a_addr | AW'(3);
  assign b0 = mem[i0];
  assign b1 = mem[i1];
  assign b2 = mem[i2];
  assign b3 = mem[i3];

  // Load extension by size and signedness.
  always_comb begin
    ld = '0;
    unique case (a_size)
      2'b00: ld = {{(DATA_WIDTH-8){b0[7] & ~a_uns}}, b0};
      2'b01: ld = {{(DATA_WIDTH-16){b1[7] & ~a_uns}}, b1, b0};
      2'b10: ld[31:0] = {b3, b2, b1, b0};
      default: ld = '0;
    endcase
  end

  // Memory array: written only on the edge that enters RESP; never reset.
  always_ff @(posedge clk) begin
    if (commit && a_we) begin
      mem[i0] <= a_wdata[7:0];
      if (a_size != 2'b00) begin
        mem[i1] <= a_wdata[15:8];
      end
      if (a_size == 2'b10) begin
        mem[i2] <= a_wdata[23:16];
        mem[i3] <= a_wdata[31:24];
      end
    end
  end

  // Request capture on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else if (fire) begin
      addr_q  <= bus.req_addr[AW-1:0];
      wdata_q <= bus.req_wdata;
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
    end
  end

  // Next state, wait counter and response registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (bad) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (WAIT_STATES == 0) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = a_we ? '0 : ld;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = a_we ? '0 : ld;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-map model predicts each
// response; monitors compare data, error, latency and hold behaviour.
module tb_data_mem_responder;
  localparam int DW  = 32;
  localparam int MB  = 131072;
  localparam int WS  = 2;
  localparam int MB0 = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst0 = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   rr_rand = 1'b0;
  logic rr_force = 1'b1;

  exp_t q[$];
  exp_t q0[$];
  exp_t me, me0;
  logic [7:0] mm[int];
  logic [7:0] mm0[int];

  data_mem_responder_if #(.DATA_WIDTH(DW)) bus();
  data_mem_responder_if #(.DATA_WIDTH(DW)) bus0();

  data_mem_responder #(
    .DATA_WIDTH(DW), .MEM_BYTES(MB), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  data_mem_responder #(
    .DATA_WIDTH(DW), .MEM_BYTES(MB0), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Response-ready driver: random or forced level.
  always @(negedge clk)
    bus.resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input bit sel, input logic we,
                                input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int nb;
    longint lim;
    logic [7:0] b;
    lim = sel ? MB0 : MB;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    rd = '0;
    if (nb == 0) err = 1'b1;
    else err = (addr % nb != 0) || (longint'(addr) + nb > lim);
    if (err) return;
    for (int i = 0; i < nb; i++) begin
      int k = int'(addr) + i;
      if (we) begin
        if (sel) mm0[k] = wd[8*i +: 8];
        else mm[k] = wd[8*i +: 8];
      end else begin
        if (sel) b = mm0.exists(k) ? mm0[k] : 8'h00;
        else b = mm.exists(k) ? mm[k] : 8'h00;
        rd |= 32'(b) << (8 * i);
      end
    end
    if (!we && !uns && nb < 4 && rd[8*nb-1])
      rd |= 32'hFFFF_FFFF << (8 * nb);
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit push);
    exp_t e;
    int t;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.req_ready) begin
      chk(1'b0, "accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (push) begin
      model(1'b0, we, sz, uns, addr, wd, e.rdata, e.err);
      e.lat = e.err ? 1 : 1 + WS;
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.resp_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(q.size() == 0, "drain_pending", 32'(q.size()), 32'd0);
  endtask

  // Monitor for the WAIT_STATES=2 responder.
  logic        pv = 1'b0;
  logic [31:0] hold_d;
  logic        hold_e;
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      chk(!bus.req_ready, "req_ready_in_resp", 32'(bus.req_ready), 32'd0);
      if (!pv) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_resp", bus.resp_rdata, 32'd0);
        end else begin
          me = q.pop_front();
          chk(bus.resp_rdata == me.rdata, "rdata", bus.resp_rdata, me.rdata);
          chk(bus.resp_err == me.err, "err", 32'(bus.resp_err), 32'(me.err));
          chk(cyc - me.acc + 1 == me.lat, "latency",
              32'(cyc - me.acc + 1), 32'(me.lat));
        end
        hold_d = bus.resp_rdata;
        hold_e = bus.resp_err;
      end else begin
        chk(bus.resp_rdata == hold_d, "rdata_stable", bus.resp_rdata, hold_d);
        chk(bus.resp_err == hold_e, "err_stable", 32'(bus.resp_err), 32'(hold_e));
      end
    end
    pv = bus.resp_valid;
  end

  // Monitor for the zero-wait-state responder.
  always @(negedge clk) begin
    if (bus0.resp_valid) begin
      if (q0.size() == 0) begin
        chk(1'b0, "b2b_unexpected_resp", bus0.resp_rdata, 32'd0);
      end else begin
        me0 = q0.pop_front();
        chk(bus0.resp_rdata == me0.rdata, "b2b_rdata", bus0.resp_rdata, me0.rdata);
        chk(bus0.resp_err == me0.err, "b2b_err", 32'(bus0.resp_err), 32'(me0.err));
        chk(cyc - me0.acc + 1 == 1, "b2b_latency", 32'(cyc - me0.acc + 1), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we, uns;
    logic [1:0] sz;
    logic [31:0] addr, wd;
    int t, acc, prev;
    exp_t e;

    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_addr = '0;
    bus0.req_wdata = '0;
    bus0.req_we = 1'b0;
    bus0.req_size = 2'b00;
    bus0.req_unsigned = 1'b0;
    bus0.resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk(bus.req_ready === 1'b1, "rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk(bus.resp_valid === 1'b0, "rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk(bus.resp_rdata === '0, "rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk(bus.resp_err === 1'b0, "rst_resp_err", 32'(bus.resp_err), 32'd0);
    rst = 1'b1;
    rst0 = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 1024; a += 4) issue(1'b1, 2'b10, 1'b0, a, $urandom, 1'b1);
    issue(1'b1, 2'b10, 1'b0, MB - 8, $urandom, 1'b1);
    issue(1'b1, 2'b10, 1'b0, MB - 4, $urandom, 1'b1);

    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);

    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h80, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);

    issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, MB - 2, 32'hCAFEF00D, 1'b1);
    issue(1'b0, 2'b10, 1'b0, MB - 4, 32'h0, 1'b1);
    issue(1'b0, 2'b01, 1'b0, MB - 2, 32'h0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, MB - 1, 32'h0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, MB, 32'h0, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1);
    drain();

    rr_force = 1'b0;
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
    t = 0;
    while (!bus.resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(bus.resp_valid, "hold_valid_rise", 32'(bus.resp_valid), 32'd1);
    @(negedge clk);
    bus.req_we = 1'b1;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h104;
    bus.req_wdata = 32'hAAAA5555;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus.resp_valid, "hold_valid_end", 32'(bus.resp_valid), 32'd1);
    rr_force = 1'b1;
    drain();
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b1);
    drain();

    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(bus.resp_valid == 1'b0, "midrst_valid", 32'(bus.resp_valid), 32'd0);
    chk(bus.resp_rdata == '0, "midrst_rdata", bus.resp_rdata, 32'd0);
    chk(bus.resp_err == 1'b0, "midrst_err", 32'(bus.resp_err), 32'd0);
    chk(bus.req_ready == 1'b1, "midrst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1);
    drain();

    rr_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 9) == 0) addr = MB - $urandom_range(1, 8);
      wd = $urandom;
      issue(we, sz, uns, addr, wd, 1'b1);
    end
    rr_rand = 1'b0;
    rr_force = 1'b1;
    @(negedge clk);
    drain();

    bus0.req_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      addr = 32'((k / 2) * 4);
      if (k % 2 == 0) begin
        we = 1'b1;
        sz = 2'b10;
        uns = 1'b0;
        wd = $urandom;
      end else begin
        we = 1'b0;
        sz = 2'($urandom_range(0, 2));
        uns = 1'($urandom_range(0, 1));
        wd = 32'h0;
        if (sz == 2'b00) addr += 32'($urandom_range(0, 3));
        if (sz == 2'b01) addr += 32'($urandom_range(0, 1) * 2);
      end
      bus0.req_we = we;
      bus0.req_size = sz;
      bus0.req_unsigned = uns;
      bus0.req_addr = addr;
      bus0.req_wdata = wd;
      t = 0;
      while (!bus0.req_ready && t < 10) begin
        @(posedge clk);
        #1;
        t++;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      model(1'b1, we, sz, uns, addr, wd, e.rdata, e.err);
      e.lat = 1;
      e.acc = acc;
      q0.push_back(e);
      if (k > 0) chk(acc - prev == 2, "b2b_spacing", 32'(acc - prev), 32'd2);
      prev = acc;
    end
    bus0.req_valid = 1'b0;
    t = 0;
    while (q0.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(q0.size() == 0, "b2b_pending", 32'(q0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data path width in bits.
REQ-002 SHALL have parameter MEM_BYTES, default 131072: byte capacity of the internal array.
REQ-003 SHALL have parameter WAIT_STATES, default 2, range 0..15: added access latency in cycles.

Interface
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-010 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-011 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-012 SHALL have port req_unsigned, input, 1 bit: loads zero-extend when 1, sign-extend when 0.
REQ-013 SHALL have port resp_valid, output, 1 bit: response available.
REQ-014 SHALL have port resp_ready, input, 1 bit: initiator accepts the response.
REQ-015 SHALL have port resp_rdata, output, DATA_WIDTH bits: load result; 0 for stores and errors.
REQ-016 SHALL have port resp_err, output, 1 bit: request was rejected without memory access.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL capture addr/wdata/we/size/unsigned on an edge where req_valid && req_ready, and ignore req_* inputs at all other times.
REQ-019 SHALL go IDLE->WAIT on capture with wait counter = WAIT_STATES; with WAIT_STATES=0 it SHALL go IDLE->RESP directly.
REQ-020 SHALL decrement the counter each cycle in WAIT and go WAIT->RESP on the edge where the counter is 1.
REQ-021 SHALL assert resp_valid in cycle N+1+WAIT_STATES for a request accepted at edge N; this is the latency of a good request.
REQ-022 SHALL commit stores into the array on the edge that enters RESP, and SHALL register loads from the array on that same edge.
REQ-023 SHALL store little-endian: byte writes only addr; half writes addr, addr+1; word writes addr..addr+3, from the low bits of wdata.
REQ-024 SHALL extend load data to DATA_WIDTH per req_unsigned: byte from bit 7, half from bit 15; word loads are unmodified.
REQ-025 SHALL flag an error when size=11, when a half has addr[0]=1, when a word has addr[1:0]!=0, or when addr+bytes > MEM_BYTES.
REQ-026 SHALL, on error, skip WAIT, enter RESP on the next edge with resp_err=1 and resp_rdata=0, and leave memory unchanged.
REQ-027 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-028 SHALL complete the response in the first RESP cycle when resp_ready is already 1 at resp_valid rise, giving req_ready=1 the following cycle.
REQ-029 SHALL have at most one request outstanding, and SHALL NOT accept a new request in the same cycle a response completes.

Reset
REQ-030 SHALL, while rst=0, force IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready reads 1 once rst=0.
REQ-031 SHALL drop an in-flight request when rst falls in WAIT; its store SHALL NOT be committed, and no response SHALL follow.
REQ-032 SHALL NOT reset the memory array contents.

Verification (WAIT_STATES=2 unless noted)
REQ-033 SHALL verify: word store 0xDEADBEEF @0x100, then lw @0x100 -> resp_rdata=0xDEADBEEF; resp_valid exactly 3 cycles after each accept.
REQ-034 SHALL verify: sb 0x80 @0x101 over 0x00000000, then lb @0x101 -> 0xFFFFFF80; lbu @0x101 -> 0x00000080; lw @0x100 -> 0x00008000.
REQ-035 SHALL verify: lh @0x103 -> resp_err=1, rdata=0, resp_valid 1 cycle after accept; sw @MEM_BYTES-2 -> resp_err=1 with memory unchanged.
REQ-036 SHALL verify: resp_ready held 0 for 5 cycles -> resp_valid/rdata stable and req_ready=0 throughout; a req_valid pulse then is not accepted.
REQ-037 SHALL verify: sw 0x12345678 @0x200 accepted, rst pulsed low in WAIT -> outputs zero, req_ready=1, and a later lw @0x200 returns the prior value.
REQ-038 SHALL verify: WAIT_STATES=0 with resp_ready tied 1 -> back-to-back requests accepted every 2 cycles with correct data.
